fp_mul: RTL and testbench

FP_MUL -- requirements
Module: fp_mul

---
 rtl/fp_mul.sv | 191 +++++++++++++++++++
 tb/tb_fp_mul.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul.sv
// Three-stage pipelined IEEE-754 style multiplier behind an operand register.
// Denormals are read as zero, results below normal flush to zero, NaN is canonical.
module fp_mul #(
  parameter int I_EXP  = 8,
  parameter int I_MNT  = 23,
  parameter int I_DATA = I_EXP + I_MNT + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [I_DATA-1:0] idataA,
  input  logic [I_DATA-1:0] idataB,
  output logic [I_DATA-1:0] odata,
  output logic              out_valid
);

  localparam int MW = I_MNT + 1;   // mantissa including hidden bit
  localparam int PW = 2 * MW;      // full product width
  localparam int EW = I_EXP + 2;   // signed exponent with overflow/underflow headroom

  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (I_EXP - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << I_EXP) - 1);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } cls_e;

  function automatic cls_e classify(input logic [I_EXP-1:0] e, input logic [I_MNT-1:0] f);
    if (e == '0)      return CLS_ZERO;
    else if (&e)      return (f == '0) ? CLS_INF : CLS_NAN;
    else              return CLS_NORM;
  endfunction

  // ---------------- stage 0: operand capture ----------------
  logic              s0_valid;
  logic [I_DATA-1:0] s0_a, s0_b;

  // NOTE: every pipeline register, data included, is cleared by reset so no
  // stale operand can leak out after release and odata reads 0 during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_valid <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all stages sampling pre-edge values.
      s0_valid <= in_valid;
      if (in_valid) begin
        s0_a <= idataA;
        s0_b <= idataB;
      end
    end
  end

  // ---------------- stage 1: unpack, classify, multiply ----------------
  logic [I_EXP-1:0]        ea, eb;
  logic [I_MNT-1:0]        fa, fb;
  cls_e                    ca, cb, cls_1;
  logic signed [EW-1:0]    exp_sum;

  assign ea      = s0_a[I_DATA-2 -: I_EXP];
  assign eb      = s0_b[I_DATA-2 -: I_EXP];
  assign fa      = s0_a[I_MNT-1:0];
  assign fb      = s0_b[I_MNT-1:0];
  assign ca      = classify(ea, fa);
  assign cb      = classify(eb, fb);
  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  // NaN wins, then inf x zero is invalid, then any inf, then any zero.
  always_comb begin
    if (ca == CLS_NAN || cb == CLS_NAN)                                  cls_1 = CLS_NAN;
    else if ((ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF)) cls_1 = CLS_NAN;
    else if (ca == CLS_INF || cb == CLS_INF)                             cls_1 = CLS_INF;
    else if (ca == CLS_ZERO || cb == CLS_ZERO)                           cls_1 = CLS_ZERO;
    else                                                                 cls_1 = CLS_NORM;
  end

  logic                 s1_valid, s1_sign;
  cls_e                 s1_cls;
  logic signed [EW-1:0] s1_exp;
  logic [PW-1:0]        s1_prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= CLS_ZERO;
      s1_exp   <= '0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_sign <= s0_a[I_DATA-1] ^ s0_b[I_DATA-1];
        s1_cls  <= cls_1;
        s1_exp  <= exp_sum;
        s1_prod <= PW'({1'b1, fa}) * PW'({1'b1, fb});
      end
    end
  end

  // ---------------- stage 2: normalize and round to nearest even ----------------
  logic [MW-1:0]        mant;
  logic [MW:0]          mant_rnd;
  logic                 grd, rnd, stk, round_up;
  logic signed [EW-1:0] norm_exp, rnd_exp;
  logic [I_MNT-1:0]     frac_2;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    norm_exp = s1_exp;
    mant     = s1_prod[PW-2 -: MW];
    grd      = s1_prod[PW-2-MW];
    rnd      = s1_prod[PW-3-MW];
    stk      = |s1_prod[PW-4-MW:0];
    // Product in [2,4): the bit dropped by the shift joins the sticky bit.
    if (s1_prod[PW-1]) begin
      norm_exp = s1_exp + EXP_ONE;
      mant     = s1_prod[PW-1 -: MW];
      grd      = s1_prod[PW-1-MW];
      rnd      = s1_prod[PW-2-MW];
      stk      = |s1_prod[PW-3-MW:0];
    end
    round_up = grd & (rnd | stk | mant[0]);
    mant_rnd = {1'b0, mant} + (MW + 1)'(round_up);
    rnd_exp  = norm_exp;
    frac_2   = mant_rnd[I_MNT-1:0];
    if (mant_rnd[MW]) begin
      rnd_exp = norm_exp + EXP_ONE;
      frac_2  = mant_rnd[I_MNT:1];
    end
  end

  logic                 s2_valid, s2_sign;
  cls_e                 s2_cls;
  logic signed [EW-1:0] s2_exp;
  logic [I_MNT-1:0]     s2_frac;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_cls   <= CLS_ZERO;
      s2_exp   <= '0;
      s2_frac  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_cls  <= s1_cls;
        s2_exp  <= rnd_exp;
        s2_frac <= frac_2;
      end
    end
  end

  // ---------------- stage 3: special cases and packing ----------------
  logic [I_DATA-1:0] result;

  always_comb begin
    result = {s2_sign, {(I_DATA-1){1'b0}}};
    case (s2_cls)
      CLS_NAN:  result = {1'b0, {I_EXP{1'b1}}, 1'b1, {(I_MNT-1){1'b0}}};
      CLS_INF:  result = {s2_sign, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
      CLS_ZERO: result = {s2_sign, {(I_DATA-1){1'b0}}};
      CLS_NORM: begin
        if (s2_exp >= EXP_MAX)
          result = {s2_sign, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
        else if (s2_exp <= 0)
          result = {s2_sign, {(I_DATA-1){1'b0}}};
        else
          result = {s2_sign, s2_exp[I_EXP-1:0], s2_frac};
      end
      default:  result = {s2_sign, {(I_DATA-1){1'b0}}};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      odata     <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) odata <= result;
    end
  end

endmodule

// File: tb/tb_fp_mul.sv
// Scoreboard bench for fp_mul: directed IEEE vectors, a streaming run against an
// integer reference model, and a mid-flight reset that must discard in-flight pairs.
module tb_fp_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] idata_a = '0, idata_b = '0;
  logic [31:0] odata;
  logic        out_valid;

  always #5 clk = ~clk;

  fp_mul dut (
    .clk      (clk),
    .reset    (rst_n),
    .in_valid (in_valid),
    .idataA   (idata_a),
    .idataB   (idata_b),
    .odata    (odata),
    .out_valid(out_valid)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] exp_q[$];
  int          iss_q[$];
  logic [31:0] last_exp = '0;
  vec_t        dir_vecs [0:14];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // Exact integer product, rounded by quotient/remainder against half an ulp.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, e, sh;
    bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint p, q, r, half;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return 32'h7FC00000;
    if (a_inf || b_inf)   return {s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {s, 31'h0};
    p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    e  = ea + eb - 127;
    sh = 23;
    if (p >= (64'sd1 <<< 47)) begin
      sh = 24;
      e++;
    end
    q    = p >>> sh;
    r    = p - (q <<< sh);
    half = 64'sd1 <<< (sh - 1);
    if (r > half || (r == half && q[0])) q++;
    if (q == (64'sd1 <<< 24)) begin
      q = q >>> 1;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) != 0) r[30:23] = 8'($urandom_range(64, 190));
    return r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p);
    @(negedge clk);
    in_valid = v;
    idata_a  = a;
    idata_b  = b;
    if (v) begin
      exp_q.push_back(p);
      iss_q.push_back(cyc + 1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    iss_q.delete();
    last_exp = '0;
    @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_odata", odata, 32'h0);
    rst_n = 1'b1;
  endtask

  // Monitor: out_valid must match the scoreboard every cycle; data is compared on
  // each output and must hold its last value between outputs.
  task automatic monitor_step();
    logic        exp_v;
    logic [31:0] e;
    exp_v = (iss_q.size() > 0) && (iss_q[0] + 3 <= cyc);
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
    if (exp_v) begin
      e = exp_q.pop_front();
      void'(iss_q.pop_front());
      if (out_valid) begin
        check("odata", odata, e);
        last_exp = e;
      end
    end else if (!out_valid) begin
      check("odata_hold", odata, last_exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) monitor_step();
    end
  end

  initial begin
    dir_vecs = '{
      '{32'h40000000, 32'hC0400000, 32'hC0C00000},
      '{32'h3FC00000, 32'h3FC00000, 32'h40100000},
      '{32'h7F800000, 32'h00000000, 32'h7FC00000},
      '{32'h7FC00000, 32'h3F800000, 32'h7FC00000},
      '{32'hFF800000, 32'h40000000, 32'hFF800000},
      '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000},
      '{32'h00800000, 32'h3F000000, 32'h00000000},
      '{32'h80000001, 32'h3F800000, 32'h80000000},
      '{32'h3F800001, 32'h3F800001, 32'h3F800002},
      '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE},
      '{32'h00000000, 32'hFF800000, 32'h7FC00000},
      '{32'h80000000, 32'h40400000, 32'h80000000},
      '{32'hBF800000, 32'h3F800000, 32'hBF800000},
      '{32'h3F800001, 32'h3FC00000, 32'h3FC00002},
      '{32'h3F800003, 32'h3FC00000, 32'h3FC00004}
    };

    repeat (2) @(negedge clk);
    check("init_out_valid", {31'b0, out_valid}, 32'h0);
    check("init_odata", odata, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Isolated pair: monitor requires out_valid exactly three edges after issue.
    drive(1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    idle(6);

    // Directed vectors back to back, with one bubble in the middle.
    for (int i = 0; i < 15; i++) begin
      if (i == 7) drive(1'b0, 32'h0, 32'h0, 32'h0);
      drive(1'b1, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].p);
    end
    idle(6);

    // Streaming run with random gaps.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b;
      a = rand_op();
      b = rand_op();
      if ($urandom_range(0, 3) == 0) drive(1'b0, 32'h0, 32'h0, 32'h0);
      drive(1'b1, a, b, ref_mul(a, b));
    end
    idle(6);

    // Three pairs in flight, then reset: none may emerge afterwards.
    drive(1'b1, 32'h40000000, 32'h40000000, 32'h40800000);
    drive(1'b1, 32'h40400000, 32'h40000000, 32'h40C00000);
    drive(1'b1, 32'h3F800000, 32'h40A00000, 32'h40A00000);
    hold_reset();
    idle(8);
    drive(1'b1, 32'h40400000, 32'h40400000, 32'h41100000);
    idle(1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
